unary_sum_decode: RTL and testbench



---
 rtl/unary_sum_decode_if.sv | 23 ++
 rtl/unary_sum_decode.sv | 170 +++++++++++++++++
 tb/tb_unary_sum_decode.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_sum_decode_if.sv
// unary_sum_decode_if: result port of the unary sum decoder.
// Carries the W+1 bit binary result with its valid/ready handshake.
// The master side (decoder) drives out_sum/out_valid; the slave side
// (consumer) drives out_ready.
interface unary_sum_decode_if #(
  parameter int W = 6
);
  logic [W:0] out_sum;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_sum,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_sum,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/unary_sum_decode.sv
// unary_sum_decode: turns the registered unary stream of the 6-bit unary
// adder into a W+1 bit binary sum {carry, count} per read/write frame.
// The adder's en/read_or_write controls are delayed one cycle here so they
// line up with the adder's registered dout/C outputs.
// Optional build macro: UNARY_DECODE_THERMO_CHECK_EN enables the sticky
// thermometer-code violation flag on err; without it err is tied low.
module unary_sum_decode #(
  parameter int W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              read_or_write,
  input  logic              din,
  input  logic              cin,
  unary_sum_decode_if.master out_if,
  output logic              out_overrun,
  output logic              err
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Frame tracking. The close of a frame is not a registered state: it is
  // the WRITE->READ transition itself, so the triggering cycle both emits
  // the result and acts as the first read cycle of the next frame.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic           r_en_d;
  logic           r_rw_d;
  logic [W-1:0]   r_cnt_acc;
  logic [W-1:0]   w_cnt_next;
  logic           r_carry_acc;
  logic           w_carry_next;

  logic [W:0]     r_sum;
  logic           r_valid;
  logic           r_overrun;

  logic           w_count_cycle;
  logic           w_close;
  logic           w_accept;
  logic           w_load;

  // Realign the shared controls with the adder's output register delay.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_d <= 1'b0;
      r_rw_d <= 1'b0;
    end else begin
      r_en_d <= en;
      r_rw_d <= read_or_write;
    end
  end

  // State and accumulator registers; a reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt_acc   <= '0;
      r_carry_acc <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt_acc   <= w_cnt_next;
      r_carry_acc <= w_carry_next;
    end
  end

  // Next-state and accumulator update; nothing moves while en_d is low.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt_acc;
    w_carry_next  = r_carry_acc;
    w_count_cycle = 1'b0;
    w_close       = 1'b0;
    if (r_en_d) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rw_d) begin
            w_state_next = S_READ;
            w_carry_next = r_carry_acc | cin;
          end
        end
        S_READ: begin
          w_carry_next = r_carry_acc | cin;
          if (r_rw_d) begin
            // The cycle that enters WRITE already carries a drained bit.
            w_state_next  = S_WRITE;
            w_count_cycle = 1'b1;
          end
        end
        S_WRITE: begin
          if (r_rw_d) begin
            w_count_cycle = 1'b1;
          end else begin
            // Close: hand off the result, restart with this cycle's carry.
            w_close      = 1'b1;
            w_state_next = S_READ;
            w_cnt_next   = '0;
            w_carry_next = cin;
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
    if (w_count_cycle && din && (r_cnt_acc != CNT_MAX)) begin
      w_cnt_next = r_cnt_acc + 1'b1;
    end
  end

  // A closing frame loads the output unless an unaccepted result blocks it.
  assign w_accept = r_valid & out_if.out_ready;
  assign w_load   = w_close & (~r_valid | out_if.out_ready);

  // Output register with valid/ready hold and the overrun pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_close & ~w_load;
      if (w_load) begin
        r_sum   <= {r_carry_acc, r_cnt_acc};
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_if.out_sum   = r_sum;
  assign out_if.out_valid = r_valid;
  assign out_overrun      = r_overrun;

`ifdef UNARY_DECODE_THERMO_CHECK_EN
  logic r_seen_zero;
  logic r_err;

  // A counted 1 after a counted 0 in the same frame breaks the thermometer code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen_zero <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_close) begin
        r_seen_zero <= 1'b0;
      end else if (w_count_cycle && !din) begin
        r_seen_zero <= 1'b1;
      end
      if (w_count_cycle && din && r_seen_zero) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_sum_decode.sv
// tb_unary_sum_decode: directed scenarios plus randomized frames, all
// checked every cycle against a frame-level reference model.
module tb_unary_sum_decode;
  localparam int W    = 6;
  localparam int MAXC = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic read_or_write = 1'b0;
  logic din = 1'b0;
  logic cin = 1'b0;
  logic out_overrun;
  logic err;

  unary_sum_decode_if #(.W(W)) out_if ();

  unary_sum_decode #(.W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .read_or_write (read_or_write),
    .din           (din),
    .cin           (cin),
    .out_if        (out_if),
    .out_overrun   (out_overrun),
    .err           (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: works on the stream of enabled cycles, classifying
  // each as a read or write cycle from the delayed phase select.
  logic m_en_d, m_rw_d;
  logic m_started, m_prev_rw;
  int   m_ones;
  logic m_carry, m_zero, m_err;
  logic m_valid, m_ovr;
  int   m_sum;

  task automatic model_reset();
    m_en_d = 0; m_rw_d = 0; m_started = 0; m_prev_rw = 0;
    m_ones = 0; m_carry = 0; m_zero = 0; m_err = 0;
    m_valid = 0; m_ovr = 0; m_sum = 0;
  endtask

  task automatic model_edge(input logic e, input logic rw, input logic d,
                            input logic c, input logic rdy, input logic rstn);
    logic close;
    int   res;
    close = 0;
    res   = 0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (m_en_d) begin
      if (!m_rw_d) begin
        if (m_started && m_prev_rw) begin
          close  = 1;
          res    = (int'(m_carry) << W) + ((m_ones > MAXC) ? MAXC : m_ones);
          m_ones = 0; m_carry = 0; m_zero = 0;
        end
        m_started = 1;
        m_carry   = m_carry | c;
      end else if (m_started) begin
        if (!m_prev_rw) m_carry = m_carry | c;
        if (d) begin
          if (m_zero) m_err = 1;
          m_ones++;
        end else begin
          m_zero = 1;
        end
      end
      m_prev_rw = m_rw_d;
    end
    m_ovr = 0;
    if (m_valid && rdy) begin
      $display("xfer sum=%0d", m_sum);
      m_valid = 0;
    end
    if (close) begin
      if (!m_valid) begin
        m_sum   = res;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end
    m_en_d = e;
    m_rw_d = rw;
  endtask

  // Bench bookkeeping.
  logic g_ready = 1'b1;
  int   cyc = 0;
  int   ovr_count = 0;
  int   valid_vis_cyc = -1;
  int   rw_fall_cyc = -1;
  int   frame_start = 0;
  logic obs_valid_prev = 1'b0;
  logic a_bit = 1'b0, a_c = 1'b0, a_rw_prev = 1'b0;

  task automatic step(input logic e, input logic rw, input logic d, input logic c);
    @(negedge clk);
    en = e; read_or_write = rw; din = d; cin = c; out_ready_drive();
    @(posedge clk);
    model_edge(e, rw, d, c, g_ready, rst_n);
    #1;
    cyc++;
    chk("valid", 32'(out_if.out_valid), 32'(m_valid));
    chk("sum", 32'(out_if.out_sum), 32'(m_sum));
    chk("overrun", 32'(out_overrun), 32'(m_ovr));
`ifdef UNARY_DECODE_THERMO_CHECK_EN
    chk("err", 32'(err), 32'(m_err));
`else
    chk("err", 32'(err), 32'd0);
`endif
    if (out_overrun) ovr_count++;
    if (out_if.out_valid && !obs_valid_prev) valid_vis_cyc = cyc + 1;
    obs_valid_prev = out_if.out_valid;
  endtask

  task automatic out_ready_drive();
    out_if.out_ready = g_ready;
  endtask

  // One adder input cycle: the adder registers its data, so the bit and
  // carry given here reach din/cin one cycle later.
  task automatic adder_cycle(input logic e, input logic rw, input logic b, input logic c);
    step(e, rw, a_bit, a_c);
    if (a_rw_prev && !rw) rw_fall_cyc = cyc;
    a_rw_prev = rw;
    a_bit = b;
    a_c   = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    a_bit = 0; a_c = 0; a_rw_prev = 0;
    valid_vis_cyc = -1;
    obs_valid_prev = 1'b0;
  endtask

  function automatic logic [127:0] mask(input int n);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic run_frame(input int rlen, input int wlen, input logic [127:0] pat,
                           input logic carry, input int gap_at, input int gap_len);
    frame_start = cyc + 1;
    for (int i = 0; i < rlen; i++) adder_cycle(1, 0, 0, carry && (i == 0));
    for (int j = 0; j < wlen; j++) begin
      if (j == gap_at)
        for (int k = 0; k < gap_len; k++) adder_cycle(0, 1, 0, 0);
      adder_cycle(1, 1, pat[j], 0);
    end
    adder_cycle(1, 0, 0, 0);
  endtask

  initial begin
    logic [127:0] pat;
    out_if.out_ready = 1'b1;
    model_reset();

    // Reset state.
    do_reset();
    chk("rst_sum", 32'(out_if.out_sum), 32'd0);
    chk("rst_valid", 32'(out_if.out_valid), 32'd0);
    chk("rst_overrun", 32'(out_overrun), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // 3 + 2 ones, write phase of 8 cycles.
    g_ready = 1;
    run_frame(5, 8, mask(5), 0, -1, 0);
    adder_cycle(1, 0, 0, 0);
    chk("t1_sum", 32'(out_if.out_sum), 32'd5);
    chk("t1_valid", 32'(out_if.out_valid), 32'd1);
    chk("t1_lat", 32'(valid_vis_cyc - rw_fall_cyc), 32'd2);
    chk("t1_span", 32'(valid_vis_cyc - frame_start), 32'd15);
    chk("t1_err", 32'(err), 32'd0);

    // 40 + 30 wraps: carry plus 6 ones.
    run_frame(4, 8, mask(6), 1, -1, 0);
    adder_cycle(1, 0, 0, 0);
    chk("t2_sum", 32'(out_if.out_sum), 32'd70);

    // Empty frame.
    run_frame(4, 4, mask(0), 0, -1, 0);
    adder_cycle(1, 0, 0, 0);
    chk("t3_sum", 32'(out_if.out_sum), 32'd0);
    chk("t3_valid", 32'(out_if.out_valid), 32'd1);

    // Back-pressure across two frames.
    adder_cycle(1, 0, 0, 0);
    g_ready = 0;
    ovr_count = 0;
    run_frame(3, 6, mask(5), 0, -1, 0);
    run_frame(3, 10, mask(9), 0, -1, 0);
    adder_cycle(1, 0, 0, 0);
    adder_cycle(1, 0, 0, 0);
    chk("t4_sum", 32'(out_if.out_sum), 32'd5);
    chk("t4_valid", 32'(out_if.out_valid), 32'd1);
    chk("t4_ovr", 32'(ovr_count), 32'd1);
    g_ready = 1;
    adder_cycle(1, 0, 0, 0);
    chk("t4_drop", 32'(out_if.out_valid), 32'd0);

    // Enable held low 3 cycles mid-write.
    do_reset();
    run_frame(4, 8, mask(6), 0, 3, 3);
    adder_cycle(1, 0, 0, 0);
    chk("t5_sum", 32'(out_if.out_sum), 32'd6);
    chk("t5_span", 32'(valid_vis_cyc - frame_start), 32'd17);
    chk("t5_lat", 32'(valid_vis_cyc - rw_fall_cyc), 32'd2);

    // Broken thermometer code 1,1,0,1,0.
    do_reset();
    pat = '0;
    pat[0] = 1; pat[1] = 1; pat[3] = 1;
    run_frame(3, 5, pat, 0, -1, 0);
    adder_cycle(1, 0, 0, 0);
    chk("t6_sum", 32'(out_if.out_sum), 32'd3);
`ifdef UNARY_DECODE_THERMO_CHECK_EN
    chk("t6_err", 32'(err), 32'd1);
`else
    chk("t6_err", 32'(err), 32'd0);
`endif

    // Reset mid-frame discards the partial count.
    do_reset();
    for (int i = 0; i < 3; i++) adder_cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) adder_cycle(1, 1, 1, 0);
    do_reset();
    chk("t7_valid", 32'(out_if.out_valid), 32'd0);
    run_frame(2, 4, mask(2), 0, -1, 0);
    adder_cycle(1, 0, 0, 0);
    chk("t7_sum", 32'(out_if.out_sum), 32'd2);

    // Randomized frames with random enable gaps and back-pressure.
    do_reset();
    begin
      logic rw_r;
      int   run_left;
      rw_r = 0;
      run_left = 3;
      for (int n = 0; n < 3000; n++) begin
        logic e, b, c;
        if (run_left == 0) begin
          rw_r = ~rw_r;
          if (rw_r && ($urandom_range(0, 19) == 0)) run_left = $urandom_range(60, 80);
          else run_left = $urandom_range(1, 12);
        end
        e = ($urandom_range(0, 9) != 0);
        b = rw_r && ($urandom_range(0, 3) != 0);
        c = !rw_r && ($urandom_range(0, 15) == 0);
        g_ready = ($urandom_range(0, 3) != 0);
        adder_cycle(e, rw_r, b, c);
        if (e) run_left--;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
